spi_accel_slave: RTL and testbench
==================================

// Module: spi_accel_slave
// PURPOSE
//  SPI slave model of the accelerometer, on the far side of the SPI master's
//  MOSI/SCLK/MISO/select lines. Used in simulation and in FPGA loop-back.
//  Over-samples SCLK/CS_N in the HCLK domain and decodes command/address/data
//  frames. Serves a 16 x 8-bit register file; X/Y/Z sample bytes come from
//  input ports.
// PARAMETERS
//  DEVID        8'hAD  value returned by read-only register 0x0
//  SYNC_STAGES  2      flip-flops per synchroniser on SCLK, CS_N, MOSI (>=2)
// PORTS
//  HCLK       in   1  system clock, all logic rising-edge
//  HRESETn    in   1  reset; synchronous and active-low
//  SCLK       in   1  SPI clock from master, idle low (mode 0)
//  CS_N       in   1  slave select, active low
//  MOSI       in   1  serial data from master, MSB first
//  MISO       out  1  serial data to master, MSB first
//  X_IN       in   8  live X sample byte
//  Y_IN       in   8  live Y sample byte
//  Z_IN       in   8  live Z sample byte
//  CTRL       out  8  contents of register 0x4
//  WR_STROBE  out  1  one-HCLK pulse per completed register write
//  WR_ADDR    out  4  register address of that write, valid with WR_STROBE
// BEHAVIOUR
//  - Reset: MISO=0, CTRL=0, WR_STROBE=0, WR_ADDR=0, regs 0x4-0xF=0, FSM=IDLE.
//  - Reset mid-frame aborts the frame; the partial byte is lost.
//  - SCLK, CS_N and MOSI each pass through SYNC_STAGES flops.
//  - Edges are detected on the synchronised SCLK.
//  - SCLK half-period >= SYNC_STAGES+2 HCLK; faster SCLK is unsupported.
//  - Mode 0: shift MOSI in on SCLK rise; update MISO on SCLK fall.
//  - MISO is forced to 0 whenever synchronised CS_N is high.
//  - Register map (address taken mod 16):
//      0x0 DEVID (RO); 0x1 X, 0x2 Y, 0x3 Z (RO); 0x4 CTRL (RW);
//      0x5-0xF scratch (RW).
//  - X/Y/Z are snapshotted on the falling edge of CS_N.
//    All reads in the frame return that snapshot.
//  - FSM states:
//      IDLE: CS_N falls -> CMD; clear bit counter.
//      CMD: after 8 rises; 0x0B -> ADDR (read), 0x0A -> ADDR (write),
//           any other value -> IGNORE.
//      ADDR: after 8 rises, latch addr[3:0] and go to DATA.
//            For a read, load tx_shift with reg[addr].
//      DATA read: each SCLK fall, MISO <= tx_shift[7], then shift left.
//                 After 8 rises, addr++ (wraps 0xF->0x0) and reload.
//      DATA write: after 8 rises, reg[addr] <= rx byte, unless addr is RO.
//                  RO writes are dropped with no strobe. Then addr++ and wrap.
//      IGNORE: MISO=0, no writes, until CS_N rises.
//  - CS_N rise in any state -> IDLE; the partial byte is discarded (no write).
//  - Bit counter is 3 bits and wraps at 8.
//  - Multi-byte bursts are unlimited in length.
//  - WR_STROBE is asserted 1 HCLK after the synchronised 8th rise.
//  - Register update and CTRL update happen in the same cycle as WR_STROBE.
//  - CS_N and SCLK changing in the same synchronised cycle: CS_N wins.
// TESTING
//  1. Read DEVID: frame 0B,00,xx -> MISO byte 3 = 8'hAD.
//  2. Write/readback: 0A,04,5A -> WR_STROBE x1, WR_ADDR=4, CTRL=8'h5A.
//     Then 0B,04,xx -> 8'h5A.
//  3. Burst with wrap: 0A,0F,11,22 -> reg F=11, reg 5 unchanged (0 was RO).
//     Then 0B,0F,xx,xx -> 11,AD.
//  4. Snapshot: X_IN=10; drop CS_N; set X_IN=99; send 0B,01,xx -> 8'h10.
//  5. Abort: 0A,06, then 4 bits of data, then CS_N high.
//     Expect reg 6 unchanged, no WR_STROBE, next frame decodes normally.
//  6. Bad command 0x55 -> MISO=0 for the whole frame, no register change.
//     HRESETn low mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_accel_slave.sv
// SPI mode-0 slave emulating an accelerometer: oversamples SCLK/CS_N/MOSI in
// the HCLK domain and serves a 16 x 8-bit register file over cmd/addr/data frames.
module spi_accel_slave #(
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       SCLK,
  input  logic       CS_N,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] X_IN,
  input  logic [7:0] Y_IN,
  input  logic [7:0] Z_IN,
  output logic [7:0] CTRL,
  output logic       WR_STROBE,
  output logic [3:0] WR_ADDR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  addr_q, addr_d;
  logic        is_write_q, is_write_d;
  logic        miso_q, miso_d;
  logic [7:0]  snap_x_q, snap_x_d;
  logic [7:0]  snap_y_q, snap_y_d;
  logic [7:0]  snap_z_q, snap_z_d;
  logic [7:0]  regs_q [4:15];
  logic [7:0]  regs_d [4:15];
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;

  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [7:0]  reg_view [16];

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_N};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // Unified read view: DEVID, the frame's X/Y/Z snapshot, then the RW registers
  always_comb begin
    reg_view[0] = DEVID;
    reg_view[1] = snap_x_q;
    reg_view[2] = snap_y_q;
    reg_view[3] = snap_z_q;
    for (int i = 4; i < 16; i++) reg_view[i] = regs_q[i];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    miso_d      = miso_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_z_d    = snap_z_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    // Select edges take priority over any coincident SCLK edge
    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      snap_x_d  = X_IN;
      snap_y_d  = Y_IN;
      snap_z_d  = Z_IN;
    end else begin
      if (sclk_rise && (state_q inside {ST_CMD, ST_ADDR, ST_DATA})) begin
        rx_shift_d = rx_byte[6:0];
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end
      case (state_q)
        ST_CMD: begin
          miso_d = 1'b0;
          if (byte_done) begin
            if (rx_byte == 8'h0B) begin
              state_d    = ST_ADDR;
              is_write_d = 1'b0;
            end else if (rx_byte == 8'h0A) begin
              state_d    = ST_ADDR;
              is_write_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          miso_d = 1'b0;
          if (byte_done) begin
            addr_d     = rx_byte[3:0];
            tx_shift_d = reg_view[rx_byte[3:0]];
            state_d    = ST_DATA;
          end
        end
        ST_DATA: begin
          if (is_write_q) begin
            miso_d = 1'b0;
            if (byte_done) begin
              for (int i = 4; i < 16; i++) begin
                if (addr_q == 4'(i)) begin
                  regs_d[i]   = rx_byte;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = addr_q;
                end
              end
              addr_d = addr_q + 4'd1;
            end
          end else begin
            if (sclk_fall) begin
              miso_d     = tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
            if (byte_done) begin
              addr_d     = addr_q + 4'd1;
              tx_shift_d = reg_view[addr_q + 4'd1];
            end
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      addr_q      <= 4'd0;
      is_write_q  <= 1'b0;
      miso_q      <= 1'b0;
      snap_x_q    <= 8'd0;
      snap_y_q    <= 8'd0;
      snap_z_q    <= 8'd0;
      for (int i = 4; i < 16; i++) regs_q[i] <= 8'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      miso_q      <= miso_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_z_q    <= snap_z_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign MISO      = miso_q & ~cs_s;
  assign CTRL      = regs_q[4];
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;

endmodule

// File: tb/tb_spi_accel_slave.sv
// Self-checking bench for spi_accel_slave: directed frames plus random bursts
// checked against a byte-level register-file model.
module tb_spi_accel_slave;

  localparam int HALF = 6;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       SCLK;
  logic       CS_N;
  logic       MOSI;
  logic       MISO;
  logic [7:0] X_IN, Y_IN, Z_IN;
  logic [7:0] CTRL;
  logic       WR_STROBE;
  logic [3:0] WR_ADDR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_regs [16];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [3:0] exp_wr_q [$];
  logic [3:0] mon_wr_q [$];

  spi_accel_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN), .CTRL(CTRL),
    .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR)
  );

  always #5 HCLK = ~HCLK;

  // Every HCLK cycle with WR_STROBE high is logged, so a stretched pulse shows up
  always @(negedge HCLK) if (WR_STROBE) mon_wr_q.push_back(WR_ADDR);

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic cs_low();
    m_regs[1] = X_IN;
    m_regs[2] = Y_IN;
    m_regs[3] = Z_IN;
    CS_N = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    CS_N = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = tx[i];
      wait_clks(HALF);
      rx   = {rx[6:0], MISO};
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame();
    logic [7:0] b;
    rx_q.delete();
    mon_wr_q.delete();
    cs_low();
    foreach (tx_q[i]) begin
      spi_bits(tx_q[i], 8, b);
      rx_q.push_back(b);
    end
    cs_high();
  endtask

  // Byte-level view of a frame: cmd, addr, then data bytes at successive addresses
  task automatic model_frame();
    logic [3:0] a;
    exp_q.delete();
    exp_wr_q.delete();
    a = (tx_q.size() > 1) ? tx_q[1][3:0] : 4'h0;
    foreach (tx_q[i]) begin
      if (i < 2) begin
        exp_q.push_back(8'h00);
      end else if (tx_q[0] == 8'h0B) begin
        exp_q.push_back(m_regs[a]);
        a = a + 4'd1;
      end else if (tx_q[0] == 8'h0A) begin
        exp_q.push_back(8'h00);
        if (a >= 4'h4) begin
          m_regs[a] = tx_q[i];
          exp_wr_q.push_back(a);
        end
        a = a + 4'd1;
      end else begin
        exp_q.push_back(8'h00);
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    SCLK = 1'b0;
    CS_N = 1'b1;
    MOSI = 1'b0;
    X_IN = 8'h31;
    Y_IN = 8'h32;
    Z_IN = 8'h33;
    m_regs[0] = 8'hAD;
    for (int i = 1; i < 16; i++) m_regs[i] = 8'h00;
    wait_clks(4);
    n_checks++;
    if (MISO !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_miso: got %b expected 0", MISO); end
    n_checks++;
    if (CTRL !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h expected 00", CTRL); end
    n_checks++;
    if (WR_STROBE !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe: got %b expected 0", WR_STROBE); end
    n_checks++;
    if (WR_ADDR !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", WR_ADDR); end
    HRESETn = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_devid();
    logic [7:0] want;
    tx_q = {8'h0B, 8'h00};
    for (int i = 0; i < 17; i++) tx_q.push_back(8'h00);
    frame();
    model_frame();
    for (int i = 0; i < 19; i++) begin
      if (i == 2 || i == 18) want = 8'hAD;
      else if (i == 3) want = 8'h31;
      else if (i == 4) want = 8'h32;
      else if (i == 5) want = 8'h33;
      else want = 8'h00;
      n_checks++;
      if (rx_q[i] !== want) begin
        n_fail++;
        $display("[TB] FAIL devid_burst byte %0d: got %h expected %h", i, rx_q[i], want);
      end
    end
  endtask

  task automatic test_write_readback();
    tx_q = {8'h0A, 8'h04, 8'h5A};
    frame();
    model_frame();
    n_checks++;
    if (mon_wr_q.size() != 1) begin n_fail++; $display("[TB] FAIL wr_strobe_count: got %0d expected 1", mon_wr_q.size()); end
    n_checks++;
    if (mon_wr_q[0] !== 4'h4) begin n_fail++; $display("[TB] FAIL wr_addr: got %h expected 4", mon_wr_q[0]); end
    n_checks++;
    if (CTRL !== 8'h5A) begin n_fail++; $display("[TB] FAIL ctrl_write: got %h expected 5a", CTRL); end
    tx_q = {8'h0B, 8'h04, 8'h00};
    frame();
    model_frame();
    n_checks++;
    if (rx_q[2] !== 8'h5A) begin n_fail++; $display("[TB] FAIL ctrl_readback: got %h expected 5a", rx_q[2]); end
  endtask

  task automatic test_burst_wrap();
    tx_q = {8'h0A, 8'h0F, 8'h11, 8'h22};
    frame();
    model_frame();
    n_checks++;
    if (mon_wr_q.size() != 1) begin n_fail++; $display("[TB] FAIL wrap_strobe_count: got %0d expected 1", mon_wr_q.size()); end
    n_checks++;
    if (mon_wr_q[0] !== 4'hF) begin n_fail++; $display("[TB] FAIL wrap_wr_addr: got %h expected f", mon_wr_q[0]); end
    tx_q = {8'h0B, 8'h0F, 8'h00, 8'h00};
    frame();
    model_frame();
    n_checks++;
    if (rx_q[2] !== 8'h11) begin n_fail++; $display("[TB] FAIL wrap_read_f: got %h expected 11", rx_q[2]); end
    n_checks++;
    if (rx_q[3] !== 8'hAD) begin n_fail++; $display("[TB] FAIL wrap_read_0: got %h expected ad", rx_q[3]); end
    tx_q = {8'h0B, 8'h05, 8'h00};
    frame();
    model_frame();
    n_checks++;
    if (rx_q[2] !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_reg5: got %h expected 00", rx_q[2]); end
  endtask

  task automatic test_snapshot();
    logic [7:0] b;
    X_IN = 8'h10;
    tx_q = {8'h0B, 8'h01, 8'h00};
    rx_q.delete();
    cs_low();
    X_IN = 8'h99;
    foreach (tx_q[i]) begin
      spi_bits(tx_q[i], 8, b);
      rx_q.push_back(b);
    end
    cs_high();
    n_checks++;
    if (rx_q[2] !== 8'h10) begin n_fail++; $display("[TB] FAIL snapshot_x: got %h expected 10", rx_q[2]); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    mon_wr_q.delete();
    cs_low();
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h06, 8, b);
    spi_bits(8'hF3, 4, b);
    cs_high();
    wait_clks(4);
    n_checks++;
    if (mon_wr_q.size() != 0) begin n_fail++; $display("[TB] FAIL abort_strobe: got %0d expected 0", mon_wr_q.size()); end
    tx_q = {8'h0B, 8'h06, 8'h00};
    frame();
    model_frame();
    n_checks++;
    if (rx_q[2] !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_reg6: got %h expected 00", rx_q[2]); end
  endtask

  task automatic test_bad_cmd();
    tx_q = {8'h55, 8'h04, 8'hAA, 8'hBB};
    frame();
    model_frame();
    foreach (rx_q[i]) begin
      n_checks++;
      if (rx_q[i] !== 8'h00) begin n_fail++; $display("[TB] FAIL bad_cmd_miso byte %0d: got %h expected 00", i, rx_q[i]); end
    end
    n_checks++;
    if (mon_wr_q.size() != 0) begin n_fail++; $display("[TB] FAIL bad_cmd_strobe: got %0d expected 0", mon_wr_q.size()); end
    n_checks++;
    if (CTRL !== 8'h5A) begin n_fail++; $display("[TB] FAIL bad_cmd_ctrl: got %h expected 5a", CTRL); end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int         n;
    for (int it = 0; it < 20; it++) begin
      X_IN = 8'($urandom);
      Y_IN = 8'($urandom);
      Z_IN = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: c = 8'h0B;
        2:    c = 8'h0A;
        default: begin
          c = 8'($urandom);
          if (c == 8'h0A || c == 8'h0B) c = 8'h3C;
        end
      endcase
      tx_q = {c, 8'($urandom)};
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      frame();
      model_frame();
      foreach (exp_q[i]) begin
        n_checks++;
        if (rx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("[TB] FAIL random_miso it %0d byte %0d: got %h expected %h", it, i, rx_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (mon_wr_q.size() != exp_wr_q.size()) begin
        n_fail++;
        $display("[TB] FAIL random_strobes it %0d: got %0d expected %0d", it, mon_wr_q.size(), exp_wr_q.size());
      end
      foreach (exp_wr_q[k]) begin
        n_checks++;
        if (mon_wr_q[k] !== exp_wr_q[k]) begin
          n_fail++;
          $display("[TB] FAIL random_wr_addr it %0d: got %h expected %h", it, mon_wr_q[k], exp_wr_q[k]);
        end
      end
      n_checks++;
      if (CTRL !== m_regs[4]) begin n_fail++; $display("[TB] FAIL random_ctrl it %0d: got %h expected %h", it, CTRL, m_regs[4]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] b;
    tx_q = {8'h0A, 8'h04, 8'h77, 8'h12};
    frame();
    model_frame();
    cs_low();
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h08, 8, b);
    spi_bits(8'hC5, 3, b);
    HRESETn = 1'b0;
    wait_clks(1);
    n_checks++;
    if (MISO !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_miso: got %b expected 0", MISO); end
    n_checks++;
    if (CTRL !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_ctrl: got %h expected 00", CTRL); end
    n_checks++;
    if (WR_STROBE !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_strobe: got %b expected 0", WR_STROBE); end
    n_checks++;
    if (WR_ADDR !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset_wr_addr: got %h expected 0", WR_ADDR); end
    CS_N = 1'b1;
    SCLK = 1'b0;
    wait_clks(3);
    HRESETn = 1'b1;
    wait_clks(4);
    for (int i = 4; i < 16; i++) m_regs[i] = 8'h00;
    tx_q = {8'h0B, 8'h04, 8'h00, 8'h00, 8'h00};
    frame();
    model_frame();
    for (int i = 2; i < 5; i++) begin
      n_checks++;
      if (rx_q[i] !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_regs byte %0d: got %h expected 00", i, rx_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_devid();
    test_write_readback();
    test_burst_wrap();
    test_snapshot();
    test_abort();
    test_bad_cmd();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
